rf_dump_reader: RTL and testbench
=================================

// Module: rf_dump_reader
// PURPOSE
//  Read-side sequencer for the 4x16 register file: on a start pulse it walks every
//  register through the RF's two combinational read ports (two per fetch) and
//  streams the words out one per handshake on a valid/ready port. Used for debug
//  dump and end-of-test state checks. Sits beside the datapath on the RF read ports.
// PARAMETERS
//  NUM_REGS  4   registers to dump; even, >= 2; addresses 0..NUM_REGS-1
//  ADDR_W    2   register address width; NUM_REGS <= 2**ADDR_W
//  DATA_W    16  register data width
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  start      in   1       begin a dump; sampled only in IDLE
//  rd_addr1   out  ADDR_W  to RF addr1 = base
//  rd_addr2   out  ADDR_W  to RF addr2 = base+1
//  rd_data1   in   DATA_W  from RF data1 (combinational)
//  rd_data2   in   DATA_W  from RF data2 (combinational)
//  out_valid  out  1       out_data/out_index/out_last valid
//  out_ready  in   1       consumer accepts word when out_valid & out_ready
//  out_data   out  DATA_W  register contents
//  out_index  out  ADDR_W  register number of out_data
//  out_last   out  1       word is register NUM_REGS-1
//  busy       out  1       high in FETCH/SEND_A/SEND_B
//  done       out  1       one-cycle pulse after final word accepted
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset: state=IDLE, base=0, hold_a=hold_b=0;
//    out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, rd_addr1=0, rd_addr2=1.
//  - rd_addr1=base, rd_addr2=base+1 in every state (registered base, no glitches).
//  - States: IDLE, FETCH, SEND_A, SEND_B, DONE.
//  - IDLE: start=1 -> FETCH with base=0. start=0 -> stay.
//  - FETCH (1 cycle): hold_a<=rd_data1, hold_b<=rd_data2 at end of cycle -> SEND_A.
//  - SEND_A: out_valid=1, out_data=hold_a, out_index=base; accept -> SEND_B; else hold.
//  - SEND_B: out_valid=1, out_data=hold_b, out_index=base+1, out_last=(base+2==NUM_REGS);
//    accept & last -> DONE; accept & !last -> base<=base+2, FETCH; else hold.
//  - DONE: done=1 one cycle, busy=0, base<=0 -> IDLE. start in DONE ignored.
//  - out_data/out_index/out_last held stable while out_valid & !out_ready (AXI-style);
//    out_valid never drops without acceptance except on reset. Outside SEND_A/SEND_B
//    out_valid=0, out_data=0, out_index=0, out_last=0.
//  - start while busy or in DONE: ignored, no queuing.
//  - Latency, out_ready held 1, NUM_REGS=4: start seen at edge 0; FETCH cycle 1; words
//    r0..r3 in cycles 2,3,5,6; done cycle 7; IDLE cycle 8. Throughput 2 words / 3 cycles.
//  - Coherency: each pair reflects RF at its FETCH cycle. An RF write to a fetched
//    register in the same FETCH cycle is not seen (old value captured; RF updates at edge).
//    Writes after FETCH do not alter held words.
//  - Reset mid-dump (any state): abort immediately to reset values; no done pulse.
//  - base arithmetic is ADDR_W wide; base+1 never wraps given the NUM_REGS constraints.
// TESTING
//  1 RF=0x1111,0x2222,0x3333,0x4444; start, out_ready=1 -> words 1111/0,2222/1,3333/2,
//    4444/3 in cycles 2,3,5,6; out_last only on index 3; done=1 cycle 7 only.
//  2 Same RF, out_ready=0 for 5 cycles in SEND_A then 1 -> out_valid stays 1, data 0x1111
//    stable; sequence then completes unchanged; busy high throughout.
//  3 RF write reg2<=0xBEEF in the second FETCH cycle -> dump shows old 0x3333 at index 2;
//    write reg0<=0xAAAA during SEND_B -> no effect on current dump.
//  4 start pulsed repeatedly while busy and in DONE -> exactly one dump of 4 words, one done.
//  5 reset asserted in SEND_B of first pair -> next cycle out_valid=0, busy=0, rd_addr1=0,
//    rd_addr2=1, done never pulses; new start then dumps all 4 words correctly.
//  6 out_ready toggled randomly, 200 dumps vs reference model -> word order, index, last,
//    done count match exactly; no word dropped or duplicated.

Source files
------------

// File: rtl/rf_dump_reader_if.sv
// Valid/ready word stream carrying one register-file word per handshake.
// Ports: out_valid/out_data/out_index/out_last from master, out_ready from slave.
interface rf_dump_reader_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 16
);

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/rf_dump_reader.sv
// Dump sequencer: walks the register file two words per fetch and streams them out.
// Ports: clk, reset, start, rd_addr1/2 + rd_data1/2 (RF read), dump (stream), busy, done.
module rf_dump_reader #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  rd_addr1,
    output logic [ADDR_W-1:0]  rd_addr2,
    input  logic [DATA_W-1:0]  rd_data1,
    input  logic [DATA_W-1:0]  rd_data2,
    rf_dump_reader_if.master   dump,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND_A,
        SEND_B,
        DONE
    } state_t;

    // Base of the final pair; comparing base against it avoids
    // the ADDR_W-wide wrap of base+2.
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(NUM_REGS - 2);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;
    logic              accept;
    logic              last_pair;

    assign rd_addr1  = base;
    assign rd_addr2  = base + ONE;
    assign accept    = dump.out_valid & dump.out_ready;
    assign last_pair = (base == LAST_BASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            base           <= '0;
            hold_a         <= '0;
            hold_b         <= '0;
            dump.out_valid <= 1'b0;
            dump.out_data  <= '0;
            dump.out_index <= '0;
            dump.out_last  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base  <= '0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    // RF reads are combinational; capture both words now so
                    // later RF writes cannot disturb the pair in flight.
                    hold_a         <= rd_data1;
                    hold_b         <= rd_data2;
                    dump.out_valid <= 1'b1;
                    dump.out_data  <= rd_data1;
                    dump.out_index <= base;
                    dump.out_last  <= 1'b0;
                    state          <= SEND_A;
                end

                SEND_A: begin
                    if (accept) begin
                        dump.out_data  <= hold_b;
                        dump.out_index <= base + ONE;
                        dump.out_last  <= last_pair;
                        state          <= SEND_B;
                    end else begin
                        dump.out_data  <= hold_a;
                    end
                end

                SEND_B: begin
                    if (accept) begin
                        dump.out_valid <= 1'b0;
                        dump.out_data  <= '0;
                        dump.out_index <= '0;
                        dump.out_last  <= 1'b0;
                        if (last_pair) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            base  <= base + TWO;
                            state <= FETCH;
                        end
                    end
                end

                DONE: begin
                    base  <= '0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader with an RF model and a word scoreboard.
// Ports: drives clk/reset/start/out_ready and the RF model; checks stream, busy, done.
module tb_rf_dump_reader;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic          busy;
    logic          done;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rf [N];

    word_t sb[$];
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    rf_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) dump_bus ();

    rf_dump_reader #(
        .NUM_REGS(N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2),
        .rd_data1(rd_data1),
        .rd_data2(rd_data2),
        .dump    (dump_bus),
        .busy    (busy),
        .done    (done)
    );

    // Register file model: writes land at the clock edge, reads are combinational.
    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
    end
    assign rd_data1 = rf[rd_addr1];
    assign rd_data2 = rf[rd_addr2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic push_dump;
        word_t w;
        for (int i = 0; i < N; i++) begin
            w.data = rf[i];
            w.idx  = AW'(i);
            w.last = (i == N - 1);
            sb.push_back(w);
        end
    endtask

    task automatic test_reset;
        logic [25:0] got;
        logic [25:0] exp;
        exp = {1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
        reset = 1'b1;
        tick();
        tick();
        got = {dump_bus.out_valid, dump_bus.out_data, dump_bus.out_index,
               dump_bus.out_last, busy, done, rd_addr1, rd_addr2};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL reset_hold: got %h want %h", got, exp);
        end
        reset = 1'b0;
        tick();
        got = {dump_bus.out_valid, dump_bus.out_data, dump_bus.out_index,
               dump_bus.out_last, busy, done, rd_addr1, rd_addr2};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL reset_idle: got %h want %h", got, exp);
        end
    endtask

    task automatic test_latency;
        logic [8:0] vmask;
        logic [8:0] bmask;
        logic [8:0] dmask;
        word_t      got;
        word_t      exp;
        vmask = 9'h06C;
        bmask = 9'h07E;
        dmask = 9'h080;
        dump_bus.out_ready = 1'b1;
        push_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc > 1) tick();
            tests++;
            if ({dump_bus.out_valid, busy, done} !==
                {vmask[cyc], bmask[cyc], dmask[cyc]}) begin
                fails++;
                $display("FAIL latency_c%0d: valid/busy/done %b%b%b want %b%b%b",
                         cyc, dump_bus.out_valid, busy, done,
                         vmask[cyc], bmask[cyc], dmask[cyc]);
            end
            if (dump_bus.out_valid && dump_bus.out_ready && sb.size() > 0) begin
                exp = sb.pop_front();
                got.data = dump_bus.out_data;
                got.idx  = dump_bus.out_index;
                got.last = dump_bus.out_last;
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL latency_word: got %h/%0d/%b want %h/%0d/%b",
                             got.data, got.idx, got.last, exp.data, exp.idx, exp.last);
                end
            end
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL latency_left: %0d words left want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_backpressure;
        word_t got;
        word_t exp;
        int    guard;
        dump_bus.out_ready = 1'b0;
        push_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({dump_bus.out_valid, dump_bus.out_data, dump_bus.out_index, busy}
                !== {1'b1, 16'h1111, 2'd0, 1'b1}) begin
                fails++;
                $display("FAIL bp_hold%0d: v=%b d=%h i=%0d busy=%b want 1 1111 0 1",
                         k, dump_bus.out_valid, dump_bus.out_data,
                         dump_bus.out_index, busy);
            end
            tick();
        end
        dump_bus.out_ready = 1'b1;
        guard = 0;
        while (!done && guard < 30) begin
            tests++;
            if (!busy) begin
                fails++;
                $display("FAIL bp_busy: busy=0 want 1");
            end
            if (dump_bus.out_valid && sb.size() > 0) begin
                exp = sb.pop_front();
                got.data = dump_bus.out_data;
                got.idx  = dump_bus.out_index;
                got.last = dump_bus.out_last;
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL bp_word: got %h/%0d/%b want %h/%0d/%b",
                             got.data, got.idx, got.last, exp.data, exp.idx, exp.last);
                end
            end
            tick();
            guard++;
        end
        tests++;
        if (!done || sb.size() != 0) begin
            fails++;
            $display("FAIL bp_end: done=%b left=%0d want 1 0", done, sb.size());
        end
        sb.delete();
        tick();
    endtask

    task automatic test_coherency;
        word_t got;
        word_t exp;
        int    guard;
        dump_bus.out_ready = 1'b1;
        push_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (cyc > 1) tick();
            wr_en = 1'b0;
            if (cyc == 3) begin
                wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hAAAA;
            end
            if (cyc == 4) begin
                tests++;
                if (!(busy && !dump_bus.out_valid)) begin
                    fails++;
                    $display("FAIL coh_fetch: busy=%b valid=%b want 1 0",
                             busy, dump_bus.out_valid);
                end
                wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'hBEEF;
            end
            if (dump_bus.out_valid && sb.size() > 0) begin
                exp = sb.pop_front();
                got.data = dump_bus.out_data;
                got.idx  = dump_bus.out_index;
                got.last = dump_bus.out_last;
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL coh_word: got %h/%0d/%b want %h/%0d/%b",
                             got.data, got.idx, got.last, exp.data, exp.idx, exp.last);
                end
            end
        end
        wr_en = 1'b0;
        tests++;
        if (!done || sb.size() != 0) begin
            fails++;
            $display("FAIL coh_end: done=%b left=%0d want 1 0", done, sb.size());
        end
        sb.delete();
        tick();
        // The next dump must pick up both writes.
        exp.data = 16'hAAAA; exp.idx = 2'd0; exp.last = 1'b0; sb.push_back(exp);
        exp.data = 16'h2222; exp.idx = 2'd1; sb.push_back(exp);
        exp.data = 16'hBEEF; exp.idx = 2'd2; sb.push_back(exp);
        exp.data = 16'h4444; exp.idx = 2'd3; exp.last = 1'b1; sb.push_back(exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!done && guard < 30) begin
            if (dump_bus.out_valid && sb.size() > 0) begin
                exp = sb.pop_front();
                got.data = dump_bus.out_data;
                got.idx  = dump_bus.out_index;
                got.last = dump_bus.out_last;
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL coh_new: got %h/%0d/%b want %h/%0d/%b",
                             got.data, got.idx, got.last, exp.data, exp.idx, exp.last);
                end
            end
            tick();
            guard++;
        end
        tests++;
        if (!done || sb.size() != 0) begin
            fails++;
            $display("FAIL coh_new_end: done=%b left=%0d want 1 0", done, sb.size());
        end
        sb.delete();
        tick();
    endtask

    task automatic test_start_ignored;
        word_t got;
        word_t exp;
        int    guard;
        int    dones;
        int    words;
        dump_bus.out_ready = 1'b1;
        push_dump();
        start = 1'b1;
        tick();
        guard = 0;
        dones = 0;
        words = 0;
        while (!done && guard < 30) begin
            start = 1'($urandom_range(0, 1)) | guard[0];
            if (dump_bus.out_valid) begin
                words++;
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    got.data = dump_bus.out_data;
                    got.idx  = dump_bus.out_index;
                    got.last = dump_bus.out_last;
                    tests++;
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL st_word: got %h/%0d/%b want %h/%0d/%b",
                                 got.data, got.idx, got.last,
                                 exp.data, exp.idx, exp.last);
                    end
                end
            end
            tick();
            guard++;
        end
        if (done) dones++;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done) dones++;
            if (dump_bus.out_valid) words++;
            tests++;
            if (busy || dump_bus.out_valid) begin
                fails++;
                $display("FAIL st_idle%0d: busy=%b valid=%b want 0 0",
                         k, busy, dump_bus.out_valid);
            end
            tick();
        end
        tests++;
        if (dones != 1 || words != N) begin
            fails++;
            $display("FAIL st_count: dones=%0d words=%0d want 1 %0d", dones, words, N);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid;
        word_t got;
        word_t exp;
        int    guard;
        dump_bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests++;
        if ({dump_bus.out_valid, dump_bus.out_data} !== {1'b1, rf[0]}) begin
            fails++;
            $display("FAIL rm_a: v=%b d=%h want 1 %h",
                     dump_bus.out_valid, dump_bus.out_data, rf[0]);
        end
        tick();
        dump_bus.out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({dump_bus.out_valid, busy, done, rd_addr1, rd_addr2}
            !== {1'b0, 1'b0, 1'b0, 2'd0, 2'd1}) begin
            fails++;
            $display("FAIL rm_abort: v=%b busy=%b done=%b a1=%0d a2=%0d want 0 0 0 0 1",
                     dump_bus.out_valid, busy, done, rd_addr1, rd_addr2);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (done || busy) begin
                fails++;
                $display("FAIL rm_quiet%0d: done=%b busy=%b want 0 0", k, done, busy);
            end
        end
        dump_bus.out_ready = 1'b1;
        push_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!done && guard < 30) begin
            if (dump_bus.out_valid && sb.size() > 0) begin
                exp = sb.pop_front();
                got.data = dump_bus.out_data;
                got.idx  = dump_bus.out_index;
                got.last = dump_bus.out_last;
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL rm_word: got %h/%0d/%b want %h/%0d/%b",
                             got.data, got.idx, got.last, exp.data, exp.idx, exp.last);
                end
            end
            tick();
            guard++;
        end
        tests++;
        if (!done || sb.size() != 0) begin
            fails++;
            $display("FAIL rm_end: done=%b left=%0d want 1 0", done, sb.size());
        end
        sb.delete();
        tick();
    endtask

    task automatic test_random;
        word_t got;
        word_t exp;
        word_t prev;
        logic  prev_stall;
        int    guard;
        int    dones;
        int    bad_stable;
        dones      = 0;
        bad_stable = 0;
        for (int d = 0; d < 200; d++) begin
            rf_write(AW'($urandom_range(0, N - 1)), DW'($urandom));
            for (int w = $urandom_range(0, 2); w > 0; w--) tick();
            push_dump();
            start = 1'b1;
            tick();
            start = 1'b0;
            prev_stall = 1'b0;
            prev = '0;
            guard = 0;
            while (!done && guard < 80) begin
                dump_bus.out_ready = ($urandom_range(0, 2) != 0);
                got.data = dump_bus.out_data;
                got.idx  = dump_bus.out_index;
                got.last = dump_bus.out_last;
                if (prev_stall && (!dump_bus.out_valid || got !== prev))
                    bad_stable++;
                if (dump_bus.out_valid && dump_bus.out_ready) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL rnd_extra: got %h/%0d/%b with empty queue",
                                 got.data, got.idx, got.last);
                    end else begin
                        exp = sb.pop_front();
                        if (got !== exp) begin
                            fails++;
                            $display("FAIL rnd_word: dump %0d got %h/%0d/%b want %h/%0d/%b",
                                     d, got.data, got.idx, got.last,
                                     exp.data, exp.idx, exp.last);
                        end
                    end
                end
                prev_stall = dump_bus.out_valid && !dump_bus.out_ready;
                prev = got;
                tick();
                guard++;
            end
            if (done) dones++;
            tests++;
            if (!done || sb.size() != 0) begin
                fails++;
                $display("FAIL rnd_end: dump %0d done=%b left=%0d want 1 0",
                         d, done, sb.size());
                sb.delete();
            end
            tick();
        end
        tests++;
        if (dones != 200 || bad_stable != 0) begin
            fails++;
            $display("FAIL rnd_total: dones=%0d unstable=%0d want 200 0",
                     dones, bad_stable);
        end
    endtask

    initial begin
        reset              = 1'b1;
        start              = 1'b0;
        wr_en              = 1'b0;
        wr_addr            = '0;
        wr_data            = '0;
        dump_bus.out_ready = 1'b0;
        test_reset();
        rf_write(2'd0, 16'h1111);
        rf_write(2'd1, 16'h2222);
        rf_write(2'd2, 16'h3333);
        rf_write(2'd3, 16'h4444);
        test_latency();
        tick();
        test_backpressure();
        test_coherency();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
